// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline front end: boot/exception addresses,
// the bubble instruction word, the fetch state encoding and the IF/ID slot layout.
package mips_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [XLEN-1:0]   DEF_RESET_PC   = 32'h0000_0000;
  localparam logic [XLEN-1:0]   DEF_EXC_VECTOR = 32'h8000_0004;
  localparam logic [INST_W-1:0] DEF_NOP_WORD   = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_BOOT  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc_plus4;
    logic              valid;
    logic              fault;
    logic [XLEN-1:0]   fault_addr;
  } if_id_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: ROM bus, control from later stages, and the IF/ID outputs.
interface inst_fetch_if;
  import mips_pkg::*;

  logic [XLEN-1:0]   rom_addr;
  logic [INST_W-1:0] rom_data;
  logic              rom_accessable;

  logic              stall;
  logic              flush;
  logic              redirect;
  logic [XLEN-1:0]   redirect_pc;

  logic [INST_W-1:0] id_inst;
  logic [XLEN-1:0]   id_pc_plus4;
  logic              id_valid;
  logic              id_fault;
  logic [XLEN-1:0]   id_fault_addr;

  modport master (
    output rom_addr,
    input  rom_data, rom_accessable,
    input  stall, flush, redirect, redirect_pc,
    output id_inst, id_pc_plus4, id_valid, id_fault, id_fault_addr
  );

  modport slave (
    input  rom_addr,
    output rom_data, rom_accessable,
    output stall, flush, redirect, redirect_pc,
    input  id_inst, id_pc_plus4, id_valid, id_fault, id_fault_addr
  );

endinterface

// File: rtl/inst_fetch_if_id_reg.sv
// Pipeline slot register with hold and bubble controls; bubble wins over hold,
// so a flush during a stall still squashes the slot.
module if_id_reg
  import mips_pkg::*;
#(
  parameter logic [INST_W-1:0] NOP_WORD = DEF_NOP_WORD
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   hold_i,
  input  logic   bubble_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  localparam if_id_t BUBBLE = '{
    inst:       NOP_WORD,
    pc_plus4:   '0,
    valid:      1'b0,
    fault:      1'b0,
    fault_addr: '0
  };

  if_id_t slot_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= BUBBLE;
    end else if (bubble_i) begin
      slot_q <= BUBBLE;
    end else if (!hold_i) begin
      slot_q <= d_i;
    end
  end

  assign q_o = slot_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, drives the ROM address, and fills the
// IF/ID slot; bad fetches become a fault slot followed by a jump to the vector.
module inst_fetch
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0]   RESET_PC   = DEF_RESET_PC,
  parameter logic [XLEN-1:0]   EXC_VECTOR = DEF_EXC_VECTOR,
  parameter logic [INST_W-1:0] NOP_WORD   = DEF_NOP_WORD
) (
  input  logic         clk,
  input  logic         reset,
  inst_fetch_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic            fetch_ok;
  logic            slot_hold;
  logic            slot_bubble;
  if_id_t          slot_d;
  if_id_t          slot_q;

  assign bus.rom_addr = pc_q;
  assign pc_plus4     = pc_q + 32'd4;
  assign fetch_ok     = bus.rom_accessable && (pc_q[1:0] == 2'b00);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    slot_hold   = 1'b1;
    slot_bubble = 1'b0;
    slot_d      = '{inst:       bus.rom_data,
                    pc_plus4:   pc_plus4,
                    valid:      1'b1,
                    fault:      1'b0,
                    fault_addr: '0};

    unique case (state_q)
      FETCH_BOOT: begin
        slot_bubble = 1'b1;
        state_d     = FETCH_RUN;
      end

      FETCH_RUN: begin
        if (bus.redirect) begin
          // A fault on the wrong path is simply dropped along with the slot.
          pc_d        = bus.redirect_pc;
          slot_bubble = 1'b1;
        end else if (bus.flush) begin
          slot_bubble = 1'b1;
          if (!bus.stall) pc_d = pc_plus4;
        end else if (!bus.stall) begin
          slot_hold = 1'b0;
          if (!fetch_ok) begin
            slot_d.inst       = NOP_WORD;
            slot_d.valid      = 1'b0;
            slot_d.fault      = 1'b1;
            slot_d.fault_addr = pc_q;
            state_d           = FETCH_FAULT;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end

      FETCH_FAULT: begin
        if (bus.redirect) begin
          pc_d        = bus.redirect_pc;
          slot_bubble = 1'b1;
          state_d     = FETCH_RUN;
        end else if (!bus.stall) begin
          pc_d        = EXC_VECTOR;
          slot_bubble = 1'b1;
          state_d     = FETCH_RUN;
        end
      end

      default: begin
        slot_bubble = 1'b1;
        state_d     = FETCH_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_id_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (reset),
    .hold_i   (slot_hold),
    .bubble_i (slot_bubble),
    .d_i      (slot_d),
    .q_o      (slot_q)
  );

  assign bus.id_inst       = slot_q.inst;
  assign bus.id_pc_plus4   = slot_q.pc_plus4;
  assign bus.id_valid      = slot_q.valid;
  assign bus.id_fault      = slot_q.fault;
  assign bus.id_fault_addr = slot_q.fault_addr;

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
Instruction-fetch stage of the single-issue MIPS pipeline. It sits directly upstream of the instruction ROM. It owns the PC and drives the ROM address combinationally. It samples the returned word and accessibility flag, and registers the result into the IF/ID pipeline register for decode. It handles stall, flush and redirect from later stages, and converts inaccessible or misaligned fetches into a tagged fault bubble followed by a jump to the exception vector.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset (boot code base).
EXC_VECTOR, 32'h80000004, fetch target after a fetch fault (supervisor bit PC[31] set).
NOP_WORD, 32'h00000000, instruction word presented for bubbles and faults.

Ports:
clk  input  1  pipeline clock, rising edge.
reset  input  1  asynchronous, active-low reset.
rom_addr  output  32  fetch address to ROM; equals PC, combinational.
rom_data  input  32  instruction word from ROM, same cycle.
rom_accessable  input  1  ROM hit flag, same cycle.
stall  input  1  hold PC and IF/ID register (load-use hazard).
flush  input  1  squash IF/ID contents to a bubble.
redirect  input  1  branch/jump/exception taken; load PC from redirect_pc.
redirect_pc  input  32  redirect target.
id_inst  output  32  registered instruction to decode.
id_pc_plus4  output  32  registered PC+4 of id_inst.
id_valid  output  1  id_inst is a real fetched instruction.
id_fault  output  1  registered fetch fault for this slot.
id_fault_addr  output  32  PC that faulted (BadVAddr source).

Behaviour:
- Reset (reset=0, async): PC=RESET_PC, state=BOOT; id_inst=NOP_WORD, id_pc_plus4=0, id_valid=0, id_fault=0, id_fault_addr=0. Reset is honoured mid-operation with no residual state.
- States: BOOT, RUN, FAULT.
  - BOOT: one cycle after reset release, IF/ID gets a bubble and the PC is held, then state goes to RUN. This gives the ROM one settle cycle.
  - RUN: the normal fetch state.
  - FAULT: entered the cycle after a fault slot is registered.
- rom_addr = PC at all times (combinational).
- fetch_ok = rom_accessable && PC[1:0]==0. fetch_fault = !fetch_ok, evaluated in RUN only.
- RUN per-edge priority, highest first:
  1. redirect: PC=redirect_pc; IF/ID=bubble (valid=0, fault=0). Any concurrent fetch_fault is discarded as wrong-path. Stall is ignored.
  2. flush without redirect: IF/ID=bubble; PC=PC+4 unless stall is asserted (then PC is held).
  3. stall: PC and all IF/ID outputs are held unchanged.
  4. fetch_fault: id_inst=NOP_WORD, id_valid=0, id_fault=1, id_fault_addr=PC, id_pc_plus4=PC+4; PC held; state goes to FAULT.
  5. Otherwise: id_inst=rom_data, id_pc_plus4=PC+4, id_valid=1, id_fault=0; PC=PC+4.
- FAULT, one cycle:
  - If stall is asserted: everything is held and the block stays in FAULT.
  - Otherwise: PC=EXC_VECTOR; IF/ID=bubble; state goes to RUN.
  - A redirect in FAULT overrides EXC_VECTOR: redirect_pc is loaded and state goes to RUN.
- Latency: one cycle from PC to IF/ID. Back-to-back fetches at one instruction per cycle.
- PC+4 wraps modulo 2^32. 0xFFFFFFFC+4 = 0x00000000; no fault is raised by the wrap itself.
- redirect_pc[1:0]!=0 is accepted into the PC. It faults on the next RUN fetch, with id_fault_addr = the misaligned PC.
- id_fault stays high only for the single registered slot, unless held by stall.

Decomposition:
- Shared package mips_pkg:
  - RESET_PC and EXC_VECTOR defaults.
  - NOP_WORD.
  - fetch state encoding (BOOT=2'd0, RUN=2'd1, FAULT=2'd2).
  - the IF/ID bundle field widths.
- One natural sub-module, if_id_reg. It is the IF/ID register with hold and bubble controls, reusable for the ID/EX pattern. The PC/FSM logic stays in inst_fetch.

Test Plan:
- Boot sequence: reset low 3 cycles, release with ROM model (0x0→0x3c110040, 0x4→0x08100055, 0x8→0x02200008).
  Required: rom_addr=0x00000000 held one BOOT cycle with id_valid=0. Next edge gives id_inst=0x3c110040, id_pc_plus4=0x00000004, id_valid=1. Following edges give 0x08100055 then 0x02200008.
- Stall: assert stall 2 cycles while PC=0x4.
  Required: rom_addr stays 0x00000004 and IF/ID holds 0x3c110040/0x4. On release, id_inst=0x08100055.
- Redirect priority: redirect=1, redirect_pc=0x00400000 together with stall=1.
  Required: next edge PC=0x00400000 and id_valid=0. Following edge id_pc_plus4=0x00400004.
- Fetch fault: PC reaches 0x0000000C (rom_accessable=0).
  Required: id_fault=1, id_fault_addr=0x0000000C, id_valid=0, id_inst=0. Next edge rom_addr=0x80000004, id_fault=0.
- Misaligned redirect: redirect_pc=0x00400002.
  Required: one bubble, then id_fault=1 with id_fault_addr=0x00400002, then PC=0x80000004. A simultaneous redirect during the fault slot suppresses the fault.
- Reset mid-operation: drop reset while in FAULT with stall=1.
  Required: immediately (async) PC=0x00000000 and all id_* outputs at reset values. Boot then repeats as in scenario 1.
